// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier operand width and issue-controller states.
package alu_pkg;
   localparam int W_MUL = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } mul_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count; pointers wrap modulo DEPTH.
module sync_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           wdata,
   output logic [W-1:0]           rdata,
   output logic [$clog2(DEPTH):0] cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr, rptr;

   assign rdata = mem[rptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: ;
         endcase
      end
   end

   // Storage needs no reset; only entries below cnt are ever read.
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= wdata;
   end
endmodule

// File: rtl/mul_issue_ctrl.sv
// Streaming front end for the sequential Booth multiplier: operand FIFO,
// start/busy issue FSM and a valid/ready result holding register.
module mul_issue_ctrl
   import alu_pkg::*;
#(
   parameter int W     = W_MUL,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [W-1:0]           in_a,
   input  logic [W-1:0]           in_b,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [2*W-1:0]         res_out,
   output logic                   mul_start,
   output logic [W-1:0]           mul_a,
   output logic [W-1:0]           mul_b,
   input  logic                   mul_busy,
   input  logic [2*W-1:0]         mul_out,
   output logic [$clog2(DEPTH):0] fifo_cnt
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   mul_state_t     state;
   logic [2*W-1:0] head;
   logic           busy_low, res_valid_next, push, pop;

   // An X on busy (unreset multiplier) must read as "not idle".
   assign busy_low       = (mul_busy === 1'b0);
   assign res_valid_next = res_valid && !res_ready;
   assign pop            = (state == IDLE) && (fifo_cnt != '0) && !res_valid_next && busy_low;
   assign in_ready       = (fifo_cnt < FULL) || pop;
   assign push           = in_valid && in_ready;

   sync_fifo #(.W(2*W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata ({in_a, in_b}),
      .rdata (head),
      .cnt   (fifo_cnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         mul_start <= 1'b0;
         mul_a     <= '0;
         mul_b     <= '0;
         res_valid <= 1'b0;
         res_out   <= '0;
      end else begin
         if (res_valid && res_ready) res_valid <= 1'b0;
         case (state)
            IDLE: if (pop) begin
               mul_a     <= head[2*W-1:W];
               mul_b     <= head[W-1:0];
               mul_start <= 1'b1;
               state     <= ISSUE;
            end
            ISSUE: if (mul_busy === 1'b1) begin
               mul_start <= 1'b0;
               state     <= WAIT;
            end
            // Busy falls on the same edge the product lands.
            WAIT: if (busy_low) begin
               res_out   <= mul_out;
               res_valid <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
